// File: rtl/icache_fetcher.sv
// Instruction fetch unit with direct-mapped one-word-per-line cache, PC, and miss handling.
// Latency: hit delivers one cycle after the request edge; miss delivers one cycle after the memory response edge.
// Backpressure: rdy=0 freezes every register; the memory request is held until it is served or aborted.
module icache_fetcher #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int INDEX_BITS  = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   clear_flag_in,
    input  logic [ADDR_WIDTH-1:0]  clear_pc_in,
    input  logic                   icache_flush_in,
    input  logic                   iq_write_pc_sig_in,
    input  logic [ADDR_WIDTH-1:0]  iq_write_pc_val_in,
    input  logic                   iq_fetch_enable_in,
    output logic                   iq_result_enable_out,
    output logic [INSTR_WIDTH-1:0] iq_instr_out,
    output logic [ADDR_WIDTH-1:0]  iq_pc_out,
    output logic                   mc_fetch_enable_out,
    output logic [ADDR_WIDTH-1:0]  mc_addr_out,
    input  logic                   mc_result_enable_in,
    input  logic [INSTR_WIDTH-1:0] mc_data_in
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    typedef enum logic {IDLE, MISS} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic                   iq_result_enable_q, iq_result_enable_d;
    logic [INSTR_WIDTH-1:0] iq_instr_q, iq_instr_d;
    logic [ADDR_WIDTH-1:0]  iq_pc_q, iq_pc_d;
    logic                   mc_fetch_enable_q, mc_fetch_enable_d;
    logic [ADDR_WIDTH-1:0]  mc_addr_q, mc_addr_d;

    logic [TAG_W-1:0]       tag_mem  [LINES];
    logic [INSTR_WIDTH-1:0] data_mem [LINES];

    logic [INDEX_BITS-1:0]  cur_idx;
    logic [TAG_W-1:0]       cur_tag;
    logic                   hit;
    logic                   fill_we;

    assign cur_idx = pc_q[INDEX_BITS+1:2];
    assign cur_tag = pc_q[ADDR_WIDTH-1:INDEX_BITS+2];
    // Lookup sees the pre-flush valid bits, so a same-cycle flush cannot spoil a hit.
    assign hit     = valid_q[cur_idx] && (tag_mem[cur_idx] == cur_tag);

    // Next-state, PC priority and output decode; clear beats PC write beats sequential advance.
    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        iq_result_enable_d = 1'b0;
        iq_instr_d         = iq_instr_q;
        iq_pc_d            = iq_pc_q;
        mc_fetch_enable_d  = mc_fetch_enable_q;
        mc_addr_d          = mc_addr_q;
        fill_we            = 1'b0;

        if (clear_flag_in) begin
            // Abort everything; a same-cycle memory response is dropped.
            state_d           = IDLE;
            mc_fetch_enable_d = 1'b0;
            pc_d              = clear_pc_in & ALIGN_MASK;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (iq_write_pc_sig_in) begin
                        pc_d = iq_write_pc_val_in & ALIGN_MASK;
                    end else if (iq_fetch_enable_in) begin
                        if (hit) begin
                            iq_result_enable_d = 1'b1;
                            iq_instr_d         = data_mem[cur_idx];
                            iq_pc_d            = pc_q;
                            pc_d               = pc_q + ADDR_WIDTH'(4);
                        end else begin
                            mc_fetch_enable_d = 1'b1;
                            mc_addr_d         = pc_q;
                            state_d           = MISS;
                        end
                    end
                end
                MISS: begin
                    if (iq_write_pc_sig_in) begin
                        // A PC write makes the outstanding miss stale.
                        pc_d              = iq_write_pc_val_in & ALIGN_MASK;
                        mc_fetch_enable_d = 1'b0;
                        state_d           = IDLE;
                    end else if (mc_result_enable_in) begin
                        // A concurrent flush suppresses the fill but the word still goes out.
                        fill_we            = !icache_flush_in;
                        iq_result_enable_d = 1'b1;
                        iq_instr_d         = mc_data_in;
                        iq_pc_d            = pc_q;
                        pc_d               = pc_q + ADDR_WIDTH'(4);
                        mc_fetch_enable_d  = 1'b0;
                        state_d            = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Valid-bit update: flush wins over a fill to the same line.
    always_comb begin
        valid_d = valid_q;
        if (icache_flush_in) begin
            valid_d = '0;
        end else if (fill_we) begin
            valid_d[cur_idx] = 1'b1;
        end
    end

    // Control and output registers, frozen while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= IDLE;
            pc_q               <= '0;
            valid_q            <= '0;
            iq_result_enable_q <= 1'b0;
            iq_instr_q         <= '0;
            iq_pc_q            <= '0;
            mc_fetch_enable_q  <= 1'b0;
            mc_addr_q          <= '0;
        end else if (rdy) begin
            state_q            <= state_d;
            pc_q               <= pc_d;
            valid_q            <= valid_d;
            iq_result_enable_q <= iq_result_enable_d;
            iq_instr_q         <= iq_instr_d;
            iq_pc_q            <= iq_pc_d;
            mc_fetch_enable_q  <= mc_fetch_enable_d;
            mc_addr_q          <= mc_addr_d;
        end
    end

    // Tag/data arrays need no reset: the valid bits gate every read.
    always_ff @(posedge clk) begin
        if (rdy && fill_we) begin
            tag_mem[cur_idx]  <= cur_tag;
            data_mem[cur_idx] <= mc_data_in;
        end
    end

    assign iq_result_enable_out = iq_result_enable_q;
    assign iq_instr_out         = iq_instr_q;
    assign iq_pc_out            = iq_pc_q;
    assign mc_fetch_enable_out  = mc_fetch_enable_q;
    assign mc_addr_out          = mc_addr_q;

endmodule

// File: tb/tb_icache_fetcher.sv
// Directed bench for icache_fetcher: reset, miss/hit, conflict, aborts, priority, flush, stall, wrap.
// Inputs change 1ns after each rising edge; outputs are checked at that same point.
// The memory side is played by the bench with fixed, hand-timed responses.
module tb_icache_fetcher;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        clear_flag_in = 1'b0;
    logic [31:0] clear_pc_in = '0;
    logic        icache_flush_in = 1'b0;
    logic        iq_write_pc_sig_in = 1'b0;
    logic [31:0] iq_write_pc_val_in = '0;
    logic        iq_fetch_enable_in = 1'b0;
    logic        iq_result_enable_out;
    logic [31:0] iq_instr_out;
    logic [31:0] iq_pc_out;
    logic        mc_fetch_enable_out;
    logic [31:0] mc_addr_out;
    logic        mc_result_enable_in = 1'b0;
    logic [31:0] mc_data_in = '0;

    int vectors = 0;
    int miscompares = 0;

    icache_fetcher #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .INDEX_BITS(6)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rdy                  (rdy),
        .clear_flag_in        (clear_flag_in),
        .clear_pc_in          (clear_pc_in),
        .icache_flush_in      (icache_flush_in),
        .iq_write_pc_sig_in   (iq_write_pc_sig_in),
        .iq_write_pc_val_in   (iq_write_pc_val_in),
        .iq_fetch_enable_in   (iq_fetch_enable_in),
        .iq_result_enable_out (iq_result_enable_out),
        .iq_instr_out         (iq_instr_out),
        .iq_pc_out            (iq_pc_out),
        .mc_fetch_enable_out  (mc_fetch_enable_out),
        .mc_addr_out          (mc_addr_out),
        .mc_result_enable_in  (mc_result_enable_in),
        .mc_data_in           (mc_data_in)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive-only helpers (no checking).
    task automatic redirect(input logic [31:0] a);
        clear_flag_in = 1'b1; clear_pc_in = a;
        cyc();
        clear_flag_in = 1'b0;
    endtask

    task automatic fill(input logic [31:0] a, input logic [31:0] d);
        redirect(a);
        iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        mc_result_enable_in = 1'b1; mc_data_in = d; cyc(); mc_result_enable_in = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        vectors++; if (iq_result_enable_out !== 1'b0) begin miscompares++; $display("FAIL rst_res got %b want 0", iq_result_enable_out); end
        vectors++; if (mc_fetch_enable_out !== 1'b0) begin miscompares++; $display("FAIL rst_mcen got %b want 0", mc_fetch_enable_out); end
        vectors++; if ({iq_instr_out, iq_pc_out, mc_addr_out} !== 96'h0) begin miscompares++; $display("FAIL rst_buses got %h want 0", {iq_instr_out, iq_pc_out, mc_addr_out}); end
        cyc(); rst = 1'b1; cyc();
        // Move pc away from 0, then start a miss and reset in the middle of it.
        iq_write_pc_sig_in = 1'b1; iq_write_pc_val_in = 32'h48; cyc(); iq_write_pc_sig_in = 1'b0;
        iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        vectors++; if (mc_fetch_enable_out !== 1'b1 || mc_addr_out !== 32'h48) begin miscompares++; $display("FAIL rst_premiss got %b/%h want 1/00000048", mc_fetch_enable_out, mc_addr_out); end
        #2 rst = 1'b0; #1;
        vectors++; if (mc_fetch_enable_out !== 1'b0 || mc_addr_out !== 32'h0) begin miscompares++; $display("FAIL rst_async got %b/%h want 0/0", mc_fetch_enable_out, mc_addr_out); end
        cyc(); rst = 1'b1; cyc();
        iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        vectors++; if (mc_fetch_enable_out !== 1'b1 || mc_addr_out !== 32'h0) begin miscompares++; $display("FAIL rst_firstmiss got %b/%h want 1/00000000", mc_fetch_enable_out, mc_addr_out); end
        redirect(32'h0);
    endtask

    task automatic test_cold_miss_hit();
        iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        vectors++; if (mc_fetch_enable_out !== 1'b1 || mc_addr_out !== 32'h0 || iq_result_enable_out !== 1'b0) begin miscompares++; $display("FAIL cold_req got %b/%h/%b want 1/0/0", mc_fetch_enable_out, mc_addr_out, iq_result_enable_out); end
        cyc(); cyc();
        vectors++; if (mc_fetch_enable_out !== 1'b1 || mc_addr_out !== 32'h0) begin miscompares++; $display("FAIL cold_hold got %b/%h want 1/0", mc_fetch_enable_out, mc_addr_out); end
        mc_result_enable_in = 1'b1; mc_data_in = 32'h00000013; cyc(); mc_result_enable_in = 1'b0;
        vectors++; if (iq_result_enable_out !== 1'b1 || iq_instr_out !== 32'h13 || iq_pc_out !== 32'h0 || mc_fetch_enable_out !== 1'b0) begin miscompares++; $display("FAIL cold_result got %b/%h/%h/%b want 1/00000013/0/0", iq_result_enable_out, iq_instr_out, iq_pc_out, mc_fetch_enable_out); end
        cyc();
        vectors++; if (iq_result_enable_out !== 1'b0) begin miscompares++; $display("FAIL cold_pulse got %b want 0", iq_result_enable_out); end
        // pc is now 4: a fetch must miss at 0x4.
        iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        vectors++; if (mc_fetch_enable_out !== 1'b1 || mc_addr_out !== 32'h4) begin miscompares++; $display("FAIL cold_pcinc got %b/%h want 1/00000004", mc_fetch_enable_out, mc_addr_out); end
        redirect(32'h0);
        iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        vectors++; if (iq_result_enable_out !== 1'b1 || iq_instr_out !== 32'h13 || iq_pc_out !== 32'h0 || mc_fetch_enable_out !== 1'b0) begin miscompares++; $display("FAIL hit_after_fill got %b/%h/%h/%b want 1/00000013/0/0", iq_result_enable_out, iq_instr_out, iq_pc_out, mc_fetch_enable_out); end
        cyc();
    endtask

    task automatic test_conflict();
        // 0x100 shares index 0 with 0x000 but has tag 1.
        redirect(32'h100);
        iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        vectors++; if (mc_fetch_enable_out !== 1'b1 || mc_addr_out !== 32'h100) begin miscompares++; $display("FAIL conf_miss got %b/%h want 1/00000100", mc_fetch_enable_out, mc_addr_out); end
        mc_result_enable_in = 1'b1; mc_data_in = 32'hAAAA5555; cyc(); mc_result_enable_in = 1'b0;
        vectors++; if (iq_result_enable_out !== 1'b1 || iq_instr_out !== 32'hAAAA5555 || iq_pc_out !== 32'h100) begin miscompares++; $display("FAIL conf_result got %b/%h/%h want 1/aaaa5555/00000100", iq_result_enable_out, iq_instr_out, iq_pc_out); end
        redirect(32'h0);
        iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        vectors++; if (mc_fetch_enable_out !== 1'b1 || mc_addr_out !== 32'h0 || iq_result_enable_out !== 1'b0) begin miscompares++; $display("FAIL conf_evicted got %b/%h/%b want 1/0/0", mc_fetch_enable_out, mc_addr_out, iq_result_enable_out); end
        mc_result_enable_in = 1'b1; mc_data_in = 32'h00000013; cyc(); mc_result_enable_in = 1'b0;
        cyc();
    endtask

    task automatic test_clear_during_miss();
        redirect(32'h40);
        iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        vectors++; if (mc_fetch_enable_out !== 1'b1 || mc_addr_out !== 32'h40) begin miscompares++; $display("FAIL clr_req got %b/%h want 1/00000040", mc_fetch_enable_out, mc_addr_out); end
        clear_flag_in = 1'b1; clear_pc_in = 32'h80; mc_result_enable_in = 1'b1; mc_data_in = 32'hDEADBEEF;
        cyc();
        clear_flag_in = 1'b0; mc_result_enable_in = 1'b0;
        vectors++; if (iq_result_enable_out !== 1'b0 || mc_fetch_enable_out !== 1'b0) begin miscompares++; $display("FAIL clr_abort got %b/%b want 0/0", iq_result_enable_out, mc_fetch_enable_out); end
        iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        vectors++; if (mc_fetch_enable_out !== 1'b1 || mc_addr_out !== 32'h80) begin miscompares++; $display("FAIL clr_newpc got %b/%h want 1/00000080", mc_fetch_enable_out, mc_addr_out); end
        mc_result_enable_in = 1'b1; mc_data_in = 32'h80808080; cyc(); mc_result_enable_in = 1'b0;
        vectors++; if (iq_result_enable_out !== 1'b1 || iq_pc_out !== 32'h80 || iq_instr_out !== 32'h80808080) begin miscompares++; $display("FAIL clr_fill80 got %b/%h/%h want 1/00000080/80808080", iq_result_enable_out, iq_pc_out, iq_instr_out); end
        redirect(32'h40);
        iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        vectors++; if (mc_fetch_enable_out !== 1'b1 || mc_addr_out !== 32'h40 || iq_result_enable_out !== 1'b0) begin miscompares++; $display("FAIL clr_nofill got %b/%h/%b want 1/00000040/0", mc_fetch_enable_out, mc_addr_out, iq_result_enable_out); end
        redirect(32'h0);
    endtask

    task automatic test_priority();
        clear_flag_in = 1'b1; clear_pc_in = 32'h80;
        iq_write_pc_sig_in = 1'b1; iq_write_pc_val_in = 32'h200;
        cyc();
        clear_flag_in = 1'b0; iq_write_pc_sig_in = 1'b0;
        iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        vectors++; if (iq_result_enable_out !== 1'b1 || iq_pc_out !== 32'h80 || mc_fetch_enable_out !== 1'b0) begin miscompares++; $display("FAIL prio_clear got %b/%h/%b want 1/00000080/0", iq_result_enable_out, iq_pc_out, mc_fetch_enable_out); end
        // PC write during a miss aborts it; the same-cycle response is discarded.
        redirect(32'h300);
        iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        iq_write_pc_sig_in = 1'b1; iq_write_pc_val_in = 32'h0; mc_result_enable_in = 1'b1; mc_data_in = 32'h33333333;
        cyc();
        iq_write_pc_sig_in = 1'b0; mc_result_enable_in = 1'b0;
        vectors++; if (iq_result_enable_out !== 1'b0 || mc_fetch_enable_out !== 1'b0) begin miscompares++; $display("FAIL wpc_abort got %b/%b want 0/0", iq_result_enable_out, mc_fetch_enable_out); end
        iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        vectors++; if (iq_result_enable_out !== 1'b1 || iq_pc_out !== 32'h0 || iq_instr_out !== 32'h13) begin miscompares++; $display("FAIL wpc_hit got %b/%h/%h want 1/0/00000013", iq_result_enable_out, iq_pc_out, iq_instr_out); end
        cyc();
    endtask

    task automatic test_back_to_back_stall();
        for (int i = 1; i < 8; i++) fill(32'(i * 4), 32'h1000 + 32'(i * 4));
        redirect(32'h0);
        iq_fetch_enable_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            vectors++;
            if (iq_result_enable_out !== 1'b1 || iq_pc_out !== 32'(i * 4) || iq_instr_out !== ((i == 0) ? 32'h13 : 32'h1000 + 32'(i * 4))) begin
                miscompares++; $display("FAIL b2b_%0d got %b/%h/%h", i, iq_result_enable_out, iq_pc_out, iq_instr_out);
            end
        end
        iq_fetch_enable_in = 1'b0;
        cyc();
        redirect(32'h0);
        iq_fetch_enable_in = 1'b1; cyc();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            vectors++;
            if (iq_result_enable_out !== 1'b1 || iq_pc_out !== 32'h0 || iq_instr_out !== 32'h13) begin
                miscompares++; $display("FAIL stall_%0d got %b/%h/%h want 1/0/00000013", i, iq_result_enable_out, iq_pc_out, iq_instr_out);
            end
        end
        rdy = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        vectors++; if (iq_result_enable_out !== 1'b1 || iq_pc_out !== 32'h4 || iq_instr_out !== 32'h1004) begin miscompares++; $display("FAIL stall_resume got %b/%h/%h want 1/00000004/00001004", iq_result_enable_out, iq_pc_out, iq_instr_out); end
        cyc();
    endtask

    task automatic test_flush();
        icache_flush_in = 1'b1; cyc(); icache_flush_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            redirect(32'(i * 4));
            iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
            vectors++;
            if (mc_fetch_enable_out !== 1'b1 || mc_addr_out !== 32'(i * 4) || iq_result_enable_out !== 1'b0) begin
                miscompares++; $display("FAIL flush_%0d got %b/%h/%b want 1/%h/0", i, mc_fetch_enable_out, mc_addr_out, iq_result_enable_out, 32'(i * 4));
            end
        end
        redirect(32'h0);
        // Flush coinciding with a fill: word delivered, line left invalid.
        iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        mc_result_enable_in = 1'b1; mc_data_in = 32'h5A5A0000; icache_flush_in = 1'b1;
        cyc();
        mc_result_enable_in = 1'b0; icache_flush_in = 1'b0;
        vectors++; if (iq_result_enable_out !== 1'b1 || iq_instr_out !== 32'h5A5A0000) begin miscompares++; $display("FAIL flushfill_deliver got %b/%h want 1/5a5a0000", iq_result_enable_out, iq_instr_out); end
        redirect(32'h0);
        iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        vectors++; if (mc_fetch_enable_out !== 1'b1 || iq_result_enable_out !== 1'b0) begin miscompares++; $display("FAIL flushfill_invalid got %b/%b want 1/0", mc_fetch_enable_out, iq_result_enable_out); end
        redirect(32'h0);
    endtask

    task automatic test_wrap();
        fill(32'hFFFFFFFC, 32'hCAFEF00D);
        redirect(32'hFFFFFFFC);
        iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        vectors++; if (iq_result_enable_out !== 1'b1 || iq_pc_out !== 32'hFFFFFFFC || iq_instr_out !== 32'hCAFEF00D) begin miscompares++; $display("FAIL wrap_hit got %b/%h/%h want 1/fffffffc/cafef00d", iq_result_enable_out, iq_pc_out, iq_instr_out); end
        iq_fetch_enable_in = 1'b1; cyc(); iq_fetch_enable_in = 1'b0;
        vectors++; if (mc_fetch_enable_out !== 1'b1 || mc_addr_out !== 32'h0) begin miscompares++; $display("FAIL wrap_pc got %b/%h want 1/00000000", mc_fetch_enable_out, mc_addr_out); end
        redirect(32'h0);
    endtask

    initial begin
        test_reset();
        test_cold_miss_hit();
        test_conflict();
        test_clear_during_miss();
        test_priority();
        test_back_to_back_stall();
        test_flush();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
